// File: rtl/testport_tap.sv
// Test-port tap: filters stall-extended writes to the test port, frames a
// begin/end session and buffers the words in a show-ahead FIFO for the checker.
module testport_tap #(
    parameter logic [29:0] TEST_ADDR    = 30'h40,
    parameter logic [31:0] BEGIN_SYMBOL = 32'h00000932,
    parameter logic [31:0] END_SYMBOL   = 32'h00000D5D,
    parameter int          DEPTH        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [29:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic                       mem_wen,
    output logic                       out_valid,
    output logic [31:0]                out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt,
    output logic                       active,
    output logic                       done,
    output logic [15:0]                duration
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {ARMED, HELD} filter_t;
    typedef enum logic [1:0] {IDLE, STREAM, FINISHED} session_t;

    filter_t  filter_state, filter_next;
    session_t state, state_next;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          strobe, qualify, push, pop, accept, drop;
    logic [LW-1:0] level_next;

    always_comb begin
        filter_next = filter_state;
        strobe      = 1'b0;
        case (filter_state)
            ARMED: if (mem_wen) begin
                strobe      = 1'b1;
                filter_next = HELD;
            end
            HELD:  if (!mem_wen) filter_next = ARMED;
            default: filter_next = ARMED;
        endcase
    end

    assign qualify = strobe && (mem_addr == TEST_ADDR);

    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE:   if (qualify && mem_wdata == BEGIN_SYMBOL) state_next = STREAM;
            STREAM: if (qualify) begin
                push = 1'b1;
                if (mem_wdata == END_SYMBOL) state_next = FINISHED;
            end
            FINISHED: state_next = FINISHED;
            default:  state_next = IDLE;
        endcase
    end

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign pop    = out_valid && out_ready;
    assign accept = push && ((level != LW'(DEPTH)) || pop);
    assign drop   = push && !accept;

    always_comb begin
        level_next = level;
        if (accept && !pop)      level_next = level + LW'(1);
        else if (pop && !accept) level_next = level - LW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filter_state <= ARMED;
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            out_valid    <= 1'b0;
            overflow     <= 1'b0;
            drop_cnt     <= '0;
            active       <= 1'b0;
            done         <= 1'b0;
            duration     <= '0;
        end else begin
            filter_state <= filter_next;
            state        <= state_next;
            level        <= level_next;
            out_valid    <= (level_next != '0);
            active       <= (state_next == STREAM);
            done         <= (state_next == FINISHED);
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
            // Counting includes the cycle of the end event, then freezes.
            if (state == IDLE && state_next == STREAM)
                duration <= '0;
            else if (state == STREAM && duration != 16'hFFFF)
                duration <= duration + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= mem_wdata;
    end

    assign out_data = mem[rd_ptr];
endmodule
